// File: rtl/serial_adder.sv
// serial_adder -- bit-serial WIDTH-bit adder with start/done handshake.
//
// Each RUN cycle adds one bit pair (LSB first) through a full-adder cell
// built from two half_adder instances plus an OR, with a registered carry.
// The result takes WIDTH cycles from the accepted start.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the Ovf port, which
// flags signed overflow of the completed sum.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled in IDLE or DONE only
//   A, B   in   WIDTH  operands, captured on an accepted start
//   Cin    in   1      carry-in, captured on an accepted start
//   busy   out  1      addition in progress
//   done   out  1      one-cycle pulse, Sum/Carry valid
//   Sum    out  WIDTH  result register
//   Carry  out  1      carry out of the MSB
//   Ovf    out  1      signed overflow (SERIAL_ADDER_OVF_EN only)

// half_adder -- combinational half adder.
//   i_a, i_b  in   1  addends
//   o_s       out  1  sum     (i_a ^ i_b)
//   o_c       out  1  carry   (i_a & i_b)
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Holds the WIDTH-1 bits already produced; the bit computed on the last
  // edge completes the sum without ever being stored here.
  logic [WIDTH-2:0] r_psum;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_p;
  logic             w_g;
  logic             w_s;
  logic             w_t;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_next;

  half_adder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_s(w_p), .o_c(w_g));
  half_adder u_ha1 (.i_a(w_p),    .i_b(r_c),    .o_s(w_s), .o_c(w_t));

  assign w_cout = w_g | w_t;
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_next = {w_s, r_psum};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Carry   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      Ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_c     <= Cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_psum <= w_next[WIDTH-1:1];
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_c    <= w_cout;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            Sum     <= w_next;
            Carry   <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // r_c is the carry into the MSB on this edge
            Ovf     <= r_c ^ w_cout;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that chains the combinational half-adder stage into a full-adder cell and runs it one bit per clock over two operand shift registers, with a registered carry between bits. It sits directly downstream of `half_adder`: two `half_adder` instances plus an OR gate form its per-bit cell. It gives the datapath a low-area multi-cycle adder with a start/done handshake.

## Interface
Parameters:
- `WIDTH`, default 8. Operand and result width in bits; legal values are WIDTH ≥ 2.

Ports:
- `clk`  in  1  System clock. All state changes on the rising edge.
- `rst_n`  in  1  Reset. **Synchronous, active-low.**
- `start`  in  1  Request. Sampled only when the block is idle or done.
- `A`  in  WIDTH  Operand A. Captured on an accepted `start`.
- `B`  in  WIDTH  Operand B. Captured on an accepted `start`.
- `Cin`  in  1  Carry-in. Captured on an accepted `start`.
- `busy`  out  1  High while the addition is in progress.
- `done`  out  1  One-cycle pulse; marks `Sum`/`Carry` as valid.
- `Sum`  out  WIDTH  Result register.
- `Carry`  out  1  Carry-out of the MSB.
- `Ovf`  out  1  Signed overflow. Present only with `SERIAL_ADDER_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **Reset** (`rst_n`=0 at an edge): state goes to IDLE. `busy`, `done`, `Sum`, `Carry` and `Ovf` all become 0. Shift registers, carry register and bit counter clear.
- **IDLE, `start`=1:**
  - Load `A` and `B` into the operand shift registers.
  - Carry register ← `Cin`; bit counter ← 0.
  - Go to RUN.
- **IDLE, `start`=0:** stay in IDLE.
- **RUN, each cycle:**
  - Per-bit cell: s = a0 ^ b0 ^ c; c' = (a0 & b0) | (c & (a0 ^ b0)). It is built from two `half_adder` instances plus an OR.
  - Shift s into the MSB of the internal partial-sum register.
  - Shift both operands right by 1; carry register ← c'; counter increments.
  - When the counter reaches WIDTH−1, the current edge processes the last bit. On that edge:
    - Copy the completed sum into `Sum` and c' into `Carry`.
    - Go to DONE.
- **DONE:** `done`=1 for exactly this cycle.
  - If `start`=1, the new operands load as from IDLE and the state goes to RUN, so back-to-back operation has no idle gap.
  - Otherwise go to IDLE.
- `start` is ignored in RUN; no queuing.
- `Sum`/`Carry` change only on the completion edge and hold until the next completion or reset. Partial results are never visible.
- Arithmetic is modulo 2^WIDTH. {`Carry`,`Sum`} = A + B + Cin exactly.
- **Reset mid-operation:** aborts the addition. No `done` pulse, and outputs clear.

## Timing
- Let `start` be accepted at edge k.
  - `busy` is high from after edge k to after edge k+WIDTH.
  - `done` is high from after edge k+WIDTH for one cycle.
  - `Sum` and `Carry` are valid from after edge k+WIDTH.
- Latency: WIDTH cycles from accept to result.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_ADDER_OVF_EN`.
- **Defined:**
  - Port `Ovf` exists.
  - On the completion edge, `Ovf` ← (carry into MSB) ^ (carry out of MSB).
  - `Ovf` holds with `Sum` and resets to 0.
- **Undefined:** the `Ovf` port and its register are absent; all other behaviour is identical.

## Test plan
- **Basic add:** WIDTH=8, A=8'h0F, B=8'h01, Cin=0, start at edge k.
  - Expect `busy` high for 8 cycles, then `done` pulse after edge k+8.
  - Expect `Sum`=8'h10, `Carry`=0, `Ovf`=0.
- **Carry-out and Cin:**
  - A=8'hFF, B=8'h01, Cin=0 → `Sum`=8'h00, `Carry`=1, `Ovf`=0.
  - A=8'h00, B=8'h00, Cin=1 → `Sum`=8'h01, `Carry`=0.
- **Signed overflow (macro defined):** A=8'h7F, B=8'h01 → `Sum`=8'h80, `Carry`=0, `Ovf`=1.
  - Rebuild without the macro; the same vector gives the same `Sum`/`Carry`.
- **Start while busy:** start with A=8'h05, B=8'h03; pulse `start` with A=8'hAA mid-RUN.
  - The second start is ignored; `Sum`=8'h08.
  - Exactly one `done` pulse.
- **Back-to-back:** hold `start`=1 across the DONE cycle with new operands A=8'h20, B=8'h22.
  - The first result appears; the second `done` follows 9 cycles later with `Sum`=8'h42.
- **Reset mid-operation:** drive `rst_n`=0 for one edge at cycle 3 of RUN.
  - All outputs are 0; no `done` pulse.
  - The next start completes normally.
